// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register (D/E, E/M, M/W) with stall-hold,
// bubble insertion, write-enable sanitising, Tnew countdown and a stall counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W           = 32,
    parameter int unsigned REG_W            = 5,
    parameter int unsigned TNEW_W           = 2,
    parameter bit          TNEW_DEC         = 1'b1,
    parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W            = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] pc8_in,
    input  logic [DATA_W-1:0] v1_in,
    input  logic [DATA_W-1:0] v2_in,
    input  logic [DATA_W-1:0] ext_in,
    input  logic [REG_W-1:0]  a1_in,
    input  logic [REG_W-1:0]  a2_in,
    input  logic [REG_W-1:0]  a3_in,
    input  logic              we_in,
    input  logic [TNEW_W-1:0] tnew_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] pc8_out,
    output logic [DATA_W-1:0] v1_out,
    output logic [DATA_W-1:0] v2_out,
    output logic [DATA_W-1:0] ext_out,
    output logic [REG_W-1:0]  a1_out,
    output logic [REG_W-1:0]  a2_out,
    output logic [REG_W-1:0]  a3_out,
    output logic              we_out,
    output logic [TNEW_W-1:0] tnew_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pc8_q,   pc8_d;
    logic [DATA_W-1:0] v1_q,    v1_d;
    logic [DATA_W-1:0] v2_q,    v2_d;
    logic [DATA_W-1:0] ext_q,   ext_d;
    logic [REG_W-1:0]  a1_q,    a1_d;
    logic [REG_W-1:0]  a2_q,    a2_d;
    logic [REG_W-1:0]  a3_q,    a3_d;
    logic              we_q,    we_d;
    logic [TNEW_W-1:0] tnew_q,  tnew_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc8_d   = pc8_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        ext_d   = ext_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        a3_d    = a3_q;
        we_d    = we_q;
        tnew_d  = tnew_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = '0;
            pc8_d   = KEEP_PC_ON_FLUSH ? pc8_in : '0;
            v1_d    = '0;
            v2_d    = '0;
            ext_d   = '0;
            a1_d    = '0;
            a2_d    = '0;
            a3_d    = '0;
            we_d    = 1'b0;
            tnew_d  = '0;
            cnt_d   = '0;
        end else if (stall) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            valid_d = valid_in;
            instr_d = instr_in;
            pc8_d   = pc8_in;
            v1_d    = v1_in;
            v2_d    = v2_in;
            ext_d   = ext_in;
            a1_d    = a1_in;
            a2_d    = a2_in;
            // Invalid slots and writes to $0 must never reach the register file.
            a3_d    = valid_in ? a3_in : '0;
            we_d    = we_in & valid_in & (a3_in != '0);
            if (!valid_in) begin
                tnew_d = '0;
            end else if (TNEW_DEC) begin
                tnew_d = (tnew_in == '0) ? '0 : tnew_in - TNEW_W'(1);
            end else begin
                tnew_d = tnew_in;
            end
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc8_q   <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            ext_q   <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            we_q    <= 1'b0;
            tnew_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc8_q   <= pc8_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            ext_q   <= ext_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            a3_q    <= a3_d;
            we_q    <= we_d;
            tnew_q  <= tnew_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_out = valid_q;
    assign instr_out = instr_q;
    assign pc8_out   = pc8_q;
    assign v1_out    = v1_q;
    assign v2_out    = v2_q;
    assign ext_out   = ext_q;
    assign a1_out    = a1_q;
    assign a2_out    = a2_q;
    assign a3_out    = a3_q;
    assign we_out    = we_q;
    assign tnew_out  = tnew_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (default params, and TNEW_DEC=0 /
// KEEP_PC_ON_FLUSH=0 / CNT_W=2) driven together and checked against a reference model.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc8;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] ext;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic        we;
        logic [1:0]  tnew;
        logic [7:0]  cnt;
    } stage_t;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_in, we_in;
    logic [31:0] instr_in, pc8_in, v1_in, v2_in, ext_in;
    logic [4:0]  a1_in, a2_in, a3_in;
    logic [1:0]  tnew_in;

    logic        a_valid, a_we, b_valid, b_we;
    logic [31:0] a_instr, a_pc8, a_v1, a_v2, a_ext, b_instr, b_pc8, b_v1, b_v2, b_ext;
    logic [4:0]  a_a1, a_a2, a_a3, b_a1, b_a2, b_a3;
    logic [1:0]  a_tnew, b_tnew, b_cnt;
    logic [7:0]  a_cnt;

    stage_t obs_a, obs_b, exp_a, exp_b;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .instr_in(instr_in), .pc8_in(pc8_in), .v1_in(v1_in), .v2_in(v2_in), .ext_in(ext_in),
        .a1_in(a1_in), .a2_in(a2_in), .a3_in(a3_in), .we_in(we_in), .tnew_in(tnew_in),
        .valid_out(a_valid), .instr_out(a_instr), .pc8_out(a_pc8), .v1_out(a_v1),
        .v2_out(a_v2), .ext_out(a_ext), .a1_out(a_a1), .a2_out(a_a2), .a3_out(a_a3),
        .we_out(a_we), .tnew_out(a_tnew), .stall_cnt(a_cnt)
    );

    pipe_stage_reg #(
        .TNEW_DEC(1'b0), .KEEP_PC_ON_FLUSH(1'b0), .CNT_W(2)
    ) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .instr_in(instr_in), .pc8_in(pc8_in), .v1_in(v1_in), .v2_in(v2_in), .ext_in(ext_in),
        .a1_in(a1_in), .a2_in(a2_in), .a3_in(a3_in), .we_in(we_in), .tnew_in(tnew_in),
        .valid_out(b_valid), .instr_out(b_instr), .pc8_out(b_pc8), .v1_out(b_v1),
        .v2_out(b_v2), .ext_out(b_ext), .a1_out(b_a1), .a2_out(b_a2), .a3_out(b_a3),
        .we_out(b_we), .tnew_out(b_tnew), .stall_cnt(b_cnt)
    );

    assign obs_a = {a_valid, a_instr, a_pc8, a_v1, a_v2, a_ext, a_a1, a_a2, a_a3, a_we,
                    a_tnew, a_cnt};
    assign obs_b = {b_valid, b_instr, b_pc8, b_v1, b_v2, b_ext, b_a1, b_a2, b_a3, b_we,
                    b_tnew, 6'd0, b_cnt};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_stage(input string who, input stage_t o, input stage_t e);
        check({who, ".valid"}, 64'(o.valid), 64'(e.valid));
        check({who, ".instr"}, 64'(o.instr), 64'(e.instr));
        check({who, ".pc8"},   64'(o.pc8),   64'(e.pc8));
        check({who, ".v1"},    64'(o.v1),    64'(e.v1));
        check({who, ".v2"},    64'(o.v2),    64'(e.v2));
        check({who, ".ext"},   64'(o.ext),   64'(e.ext));
        check({who, ".a1"},    64'(o.a1),    64'(e.a1));
        check({who, ".a2"},    64'(o.a2),    64'(e.a2));
        check({who, ".a3"},    64'(o.a3),    64'(e.a3));
        check({who, ".we"},    64'(o.we),    64'(e.we));
        check({who, ".tnew"},  64'(o.tnew),  64'(e.tnew));
        check({who, ".cnt"},   64'(o.cnt),   64'(e.cnt));
    endtask

    // Next contents of a stage register given the inputs presented at this edge.
    function automatic stage_t model(input stage_t cur, input bit dec, input bit keep,
                                     input int cmax);
        stage_t n = cur;
        if (reset) begin
            n = '0;
        end else if (flush) begin
            n = '0;
            n.pc8 = keep ? pc8_in : 32'd0;
        end else if (stall) begin
            n.cnt = (int'(cur.cnt) >= cmax) ? 8'(cmax) : 8'(int'(cur.cnt) + 1);
        end else begin
            n.valid = valid_in;
            n.instr = instr_in;
            n.pc8   = pc8_in;
            n.v1    = v1_in;
            n.v2    = v2_in;
            n.ext   = ext_in;
            n.a1    = a1_in;
            n.a2    = a2_in;
            n.a3    = valid_in ? a3_in : 5'd0;
            n.we    = we_in && valid_in && (a3_in != 5'd0);
            if (!valid_in)                 n.tnew = 2'd0;
            else if (!dec)                 n.tnew = tnew_in;
            else if (int'(tnew_in) == 0)   n.tnew = 2'd0;
            else                           n.tnew = 2'(int'(tnew_in) - 1);
            n.cnt = 8'd0;
        end
        return n;
    endfunction

    task automatic step();
        exp_a = model(exp_a, 1'b1, 1'b1, 255);
        exp_b = model(exp_b, 1'b0, 1'b0, 3);
        @(posedge clk);
        #1;
        check_stage("A", obs_a, exp_a);
        check_stage("B", obs_b, exp_b);
    endtask

    task automatic rand_data();
        valid_in = ($urandom_range(0, 4) != 0);
        instr_in = $urandom;
        pc8_in   = $urandom;
        v1_in    = $urandom;
        v2_in    = $urandom;
        ext_in   = $urandom;
        a1_in    = 5'($urandom);
        a2_in    = 5'($urandom);
        a3_in    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        we_in    = 1'($urandom);
        tnew_in  = 2'($urandom);
    endtask

    task automatic ctrl(input logic r, input logic s, input logic f);
        reset = r;
        stall = s;
        flush = f;
    endtask

    initial begin
        exp_a = '0;
        exp_b = '0;
        rand_data();
        ctrl(1'b1, 1'b0, 1'b0);
        step();

        // Plain load of a lw with Tnew=2, then Tnew=0.
        ctrl(1'b0, 1'b0, 1'b0);
        valid_in = 1'b1; instr_in = 32'h8C22_0004; pc8_in = 32'h3008;
        a3_in = 5'd2; we_in = 1'b1; tnew_in = 2'd2;
        step();
        check("load.we", 64'(a_we), 64'd1);
        check("load.tnew", 64'(a_tnew), 64'd1);
        tnew_in = 2'd0;
        step();
        check("load.tnew0", 64'(a_tnew), 64'd0);

        // Sanitising of $0 writes and invalid slots.
        a3_in = 5'd0; we_in = 1'b1;
        step();
        check("san.we_zero", 64'(a_we), 64'd0);
        valid_in = 1'b0; a3_in = 5'd7; we_in = 1'b1; tnew_in = 2'd3;
        step();
        check("san.a3_inv", 64'(a_a3), 64'd0);
        check("san.tnew_inv", 64'(a_tnew), 64'd0);

        // Stall freezes contents while inputs keep changing.
        rand_data(); valid_in = 1'b1; pc8_in = 32'h3010; tnew_in = 2'd3;
        step();
        ctrl(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            rand_data();
            step();
            check("stall.pc8", 64'(a_pc8), 64'h3010);
            check("stall.cnt", 64'(a_cnt), 64'(i));
        end
        ctrl(1'b0, 1'b0, 1'b0);
        rand_data();
        step();
        check("release.cnt", 64'(a_cnt), 64'd0);

        // Flush takes priority over stall.
        ctrl(1'b0, 1'b1, 1'b1);
        rand_data(); pc8_in = 32'h3020;
        step();
        check("flush.pc8_keep", 64'(a_pc8), 64'h3020);
        check("flush.pc8_zero", 64'(b_pc8), 64'd0);
        check("flush.valid", 64'(a_valid), 64'd0);

        // Reset in the middle of a stall run.
        ctrl(1'b0, 1'b1, 1'b0);
        repeat (5) begin rand_data(); step(); end
        check("rstall.cnt5", 64'(a_cnt), 64'd5);
        ctrl(1'b1, 1'b1, 1'b0);
        step();
        check("rstall.cnt", 64'(a_cnt), 64'd0);

        // Long stall to saturate both counters.
        ctrl(1'b0, 1'b1, 1'b0);
        repeat (300) begin rand_data(); step(); end
        check("sat.a", 64'(a_cnt), 64'd255);
        check("sat.b", 64'(b_cnt), 64'd3);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            ctrl($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) == 0);
            rand_data();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
